// File: rtl/dsp_mac_array_if.sv
// rtl/dsp_mac_array_if.sv - operand/result bundle for dsp_mac_array
// DSP_MAC_ACCUM_EN adds the accumulator clear and sticky overflow signals.
interface dsp_mac_array_if #(
  parameter int LANES = 5
);
  logic               dsp_ce;
  logic signed [17:0] dsp_a0 [0:LANES-1];
  logic signed [17:0] dsp_b0 [0:LANES-1];
  logic signed [36:0] dsp_out [0:LANES-1];
  logic               dsp_valid;
`ifdef DSP_MAC_ACCUM_EN
  logic               dsp_acc_clr;
  logic [LANES-1:0]   dsp_ovf;

  modport master (
    output dsp_ce, dsp_a0, dsp_b0, dsp_acc_clr,
    input  dsp_out, dsp_valid, dsp_ovf
  );
  modport slave (
    input  dsp_ce, dsp_a0, dsp_b0, dsp_acc_clr,
    output dsp_out, dsp_valid, dsp_ovf
  );
`else
  modport master (
    output dsp_ce, dsp_a0, dsp_b0,
    input  dsp_out, dsp_valid
  );
  modport slave (
    input  dsp_ce, dsp_a0, dsp_b0,
    output dsp_out, dsp_valid
  );
`endif
endinterface

// File: rtl/dsp_mac_array.sv
// rtl/dsp_mac_array.sv - per-lane 18x18 signed multiplier pipeline with clock enable
// Defining DSP_MAC_ACCUM_EN appends a wrapping 37-bit accumulator with sticky overflow per lane.
module dsp_mac_array #(
  parameter int LANES   = 5,
  parameter int LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  dsp_mac_array_if.slave     bus
);

  logic signed [35:0] prod [0:LANES-1];
  logic signed [36:0] pipe [0:LATENCY-1][0:LANES-1];
  logic [LATENCY-1:0] vld;

  // Operands widened first so the full 36-bit product is formed, including (-2^17)^2.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod[i] = 36'(bus.dsp_a0[i]) * 36'(bus.dsp_b0[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        for (int i = 0; i < LANES; i++) begin
          pipe[s][i] <= '0;
        end
      end
    end else if (bus.dsp_ce) begin
      vld[0] <= 1'b1;
      for (int i = 0; i < LANES; i++) begin
        pipe[0][i] <= 37'(prod[i]);
      end
      for (int s = 1; s < LATENCY; s++) begin
        vld[s] <= vld[s-1];
        for (int i = 0; i < LANES; i++) begin
          pipe[s][i] <= pipe[s-1][i];
        end
      end
    end
  end

  assign bus.dsp_valid = vld[LATENCY-1];

`ifdef DSP_MAC_ACCUM_EN
  logic signed [36:0] acc      [0:LANES-1];
  logic signed [36:0] acc_base [0:LANES-1];
  logic signed [36:0] acc_sum  [0:LANES-1];
  logic [LANES-1:0]   acc_wrap;
  logic [LANES-1:0]   ovf_q;

  // Signed overflow: addends agree in sign but the wrapped sum does not.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      acc_base[i] = bus.dsp_acc_clr ? '0 : acc[i];
      acc_sum[i]  = acc_base[i] + pipe[LATENCY-1][i];
      acc_wrap[i] = (acc_base[i][36] == pipe[LATENCY-1][i][36]) &&
                    (acc_sum[i][36] != acc_base[i][36]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
      for (int i = 0; i < LANES; i++) begin
        acc[i] <= '0;
      end
    end else if (bus.dsp_ce) begin
      for (int i = 0; i < LANES; i++) begin
        if (vld[LATENCY-1]) begin
          acc[i] <= acc_sum[i];
        end else if (bus.dsp_acc_clr) begin
          acc[i] <= '0;
        end
        ovf_q[i] <= (bus.dsp_acc_clr ? 1'b0 : ovf_q[i]) | (vld[LATENCY-1] & acc_wrap[i]);
      end
    end
  end

  assign bus.dsp_ovf = ovf_q;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      bus.dsp_out[i] = acc[i];
    end
  end
`else
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      bus.dsp_out[i] = pipe[LATENCY-1][i];
    end
  end
`endif

endmodule

// File: tb/tb_dsp_mac_array.sv
// tb/tb_dsp_mac_array.sv - bench for dsp_mac_array at LATENCY 1 and 3 side by side
// Also covers the DSP_MAC_ACCUM_EN build when that macro is defined.
module tb_dsp_mac_array;

  localparam int LANES = 5;
  localparam longint ACC_MAX = 64'sd68719476735;
  localparam longint ACC_MIN = -64'sd68719476736;

  typedef longint vec_t [LANES];
  typedef struct {
    logic [LANES-1:0][17:0] a;
    logic [LANES-1:0][17:0] b;
    logic [LANES-1:0][36:0] e;
  } vec_row_t;

  logic clk;
  logic rst_n;

  dsp_mac_array_if #(.LANES(LANES)) bus1 ();
  dsp_mac_array_if #(.LANES(LANES)) bus3 ();

  dsp_mac_array #(.LANES(LANES), .LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  dsp_mac_array #(.LANES(LANES), .LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  int       checks;
  int       failures;
  int       opa [LANES];
  int       opb [LANES];
  bit       acc_clr;
  vec_t     hist [$];
  longint   acc_m [2][LANES];
  bit       ovf_m [2][LANES];
  vec_row_t tbl [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic longint wrap37(input longint x);
    longint t;
    t = x <<< 27;
    return t >>> 27;
  endfunction

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  function automatic longint dut_out(input int d, input int i);
    return (d == 0) ? longint'(bus1.dsp_out[i]) : longint'(bus3.dsp_out[i]);
  endfunction

  function automatic longint dut_valid(input int d);
    return (d == 0) ? longint'(bus1.dsp_valid) : longint'(bus3.dsp_valid);
  endfunction

`ifdef DSP_MAC_ACCUM_EN
  function automatic longint dut_ovf(input int d, input int i);
    return (d == 0) ? longint'(bus1.dsp_ovf[i]) : longint'(bus3.dsp_ovf[i]);
  endfunction
`endif

  function automatic void model_reset();
    hist.delete();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < LANES; i++) begin
        acc_m[d][i] = 0;
        ovf_m[d][i] = 1'b0;
      end
    end
  endfunction

  // One enabled edge: accumulators consume what sat in the last stage before it, then the new products enter.
  function automatic void model_edge();
    vec_t p;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < LANES; i++) begin
        longint s;
        if (acc_clr) begin
          acc_m[d][i] = 0;
          ovf_m[d][i] = 1'b0;
        end
        if (hist.size() >= lat_of(d)) begin
          s = acc_m[d][i] + hist[lat_of(d)-1][i];
          if (s > ACC_MAX || s < ACC_MIN) ovf_m[d][i] = 1'b1;
          acc_m[d][i] = wrap37(s);
        end
      end
    end
    for (int i = 0; i < LANES; i++) p[i] = longint'(opa[i]) * longint'(opb[i]);
    hist.push_front(p);
    while (hist.size() > 4) void'(hist.pop_back());
  endfunction

  task automatic check_model(input string tag);
    for (int d = 0; d < 2; d++) begin
      int  l = lat_of(d);
      bit  v = (hist.size() >= l);
      chk($sformatf("%s_valid_L%0d", tag, l), dut_valid(d), longint'(v));
      for (int i = 0; i < LANES; i++) begin
        longint e;
`ifdef DSP_MAC_ACCUM_EN
        e = acc_m[d][i];
        chk($sformatf("%s_ovf_L%0d_lane%0d", tag, l, i), dut_ovf(d, i), longint'(ovf_m[d][i]));
`else
        e = v ? hist[l-1][i] : 0;
`endif
        chk($sformatf("%s_out_L%0d_lane%0d", tag, l, i), dut_out(d, i), e);
      end
    end
  endtask

  task automatic drive(input bit ce);
    for (int i = 0; i < LANES; i++) begin
      bus1.dsp_a0[i] = 18'(opa[i]);
      bus1.dsp_b0[i] = 18'(opb[i]);
      bus3.dsp_a0[i] = 18'(opa[i]);
      bus3.dsp_b0[i] = 18'(opb[i]);
    end
    bus1.dsp_ce = ce;
    bus3.dsp_ce = ce;
`ifdef DSP_MAC_ACCUM_EN
    bus1.dsp_acc_clr = acc_clr;
    bus3.dsp_acc_clr = acc_clr;
`endif
  endtask

  task automatic step(input bit ce, input string tag);
    drive(ce);
    @(posedge clk);
    if (ce) model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic set_ops(input int a, input int b);
    for (int i = 0; i < LANES; i++) begin
      opa[i] = a;
      opb[i] = b;
    end
  endtask

  // Asynchronous pulse placed between edges; outputs must clear before any clock arrives.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model("reset_now");
    chk("reset_valid_L3_now", longint'(bus3.dsp_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_row(input int k, input int aa [LANES], input int bb [LANES], input longint ee [LANES]);
    for (int i = 0; i < LANES; i++) begin
      tbl[k].a[i] = 18'(aa[i]);
      tbl[k].b[i] = 18'(bb[i]);
      tbl[k].e[i] = 37'(ee[i]);
    end
  endtask

  function automatic int rand_op();
    logic signed [17:0] r;
    case ($urandom_range(0, 5))
      0:       return -131072;
      1:       return 131071;
      default: begin
        r = 18'($urandom);
        return int'(r);
      end
    endcase
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    acc_clr  = 1'b0;
    rst_n    = 1'b0;
    set_ops(0, 0);
    drive(1'b0);
    model_reset();
    #2;
    check_model("por");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    set_row(0, '{3, 0, 0, 0, -5}, '{7, 0, 0, 0, 9}, '{21, 0, 0, 0, -45});
    set_row(1, '{-131072, -131072, -131072, -131072, -131072},
               '{-131072, -131072, -131072, -131072, -131072},
               '{64'sd17179869184, 64'sd17179869184, 64'sd17179869184, 64'sd17179869184, 64'sd17179869184});
    set_row(2, '{-131072, -131072, -131072, -131072, -131072},
               '{131071, 131071, 131071, 131071, 131071},
               '{-64'sd17179738112, -64'sd17179738112, -64'sd17179738112, -64'sd17179738112, -64'sd17179738112});
    set_row(3, '{131071, 0, 131071, 1, -1}, '{131071, 131071, -131072, -131072, -131072},
               '{64'sd17179607041, 0, -64'sd17179738112, -131072, 131072});
    set_row(4, '{1, 2, 3, 4, 5}, '{-1, -2, -3, -4, -5}, '{-1, -4, -9, -16, -25});

    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < LANES; i++) begin
        opa[i] = int'($signed(tbl[k].a[i]));
        opb[i] = int'($signed(tbl[k].b[i]));
      end
      step(1'b1, $sformatf("tbl%0d", k));
      chk($sformatf("tbl%0d_valid_L1", k), longint'(bus1.dsp_valid), 1);
`ifndef DSP_MAC_ACCUM_EN
      for (int i = 0; i < LANES; i++) begin
        chk($sformatf("tbl%0d_const_lane%0d", k, i), longint'(bus1.dsp_out[i]), longint'($signed(tbl[k].e[i])));
      end
`endif
    end

    // Stall on the second cycle: LATENCY=3 result arrives after the fourth clock.
    pulse_reset();
    set_ops(2, 2);
    step(1'b1, "stall_c1");
    set_ops(0, 0);
    step(1'b0, "stall_c2");
`ifndef DSP_MAC_ACCUM_EN
    chk("stall_hold_L1", longint'(bus1.dsp_out[0]), 4);
`endif
    chk("stall_valid_L3_c2", longint'(bus3.dsp_valid), 0);
    step(1'b1, "stall_c3");
    chk("stall_valid_L3_c3", longint'(bus3.dsp_valid), 0);
    step(1'b1, "stall_c4");
    chk("stall_valid_L3_c4", longint'(bus3.dsp_valid), 1);
`ifndef DSP_MAC_ACCUM_EN
    chk("stall_out_L3_c4", longint'(bus3.dsp_out[0]), 4);
`endif
    step(1'b1, "stall_c5");

    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < LANES; i++) begin
        opa[i] = rand_op();
        opb[i] = rand_op();
      end
      acc_clr = ($urandom_range(0, 7) == 0);
      step($urandom_range(0, 3) != 0, "rand");
    end
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < LANES; i++) begin
        opa[i] = rand_op();
        opb[i] = rand_op();
      end
      step(n[0] == 1'b0, "toggle");
    end
    acc_clr = 1'b0;

    // Reset with results in flight, then a stalled restart.
    step(1'b1, "mid_a");
    step(1'b1, "mid_b");
    pulse_reset();
    step(1'b1, "post_1");
    chk("post_valid_L1_e1", longint'(bus1.dsp_valid), 1);
    chk("post_valid_L3_e1", longint'(bus3.dsp_valid), 0);
    step(1'b0, "post_s");
    step(1'b1, "post_2");
    chk("post_valid_L3_e2", longint'(bus3.dsp_valid), 0);
    step(1'b1, "post_3");
    chk("post_valid_L3_e3", longint'(bus3.dsp_valid), 1);

`ifdef DSP_MAC_ACCUM_EN
    pulse_reset();
    set_ops(1, 1);
    acc_clr = 1'b1;
    step(1'b1, "acc9_1");
    acc_clr = 1'b0;
    for (int n = 0; n < 8; n++) step(1'b1, "acc9");
    set_ops(0, 0);
    step(1'b1, "acc9_end");
    chk("acc_nine", longint'(bus1.dsp_out[0]), 9);
    set_ops(4, 5);
    step(1'b1, "acc20_a");
    acc_clr = 1'b1;
    step(1'b1, "acc20_b");
    chk("acc_clr_20", longint'(bus1.dsp_out[0]), 20);
    acc_clr = 1'b0;

    pulse_reset();
    set_ops(-131072, -131072);
    for (int n = 0; n < 5; n++) step(1'b1, "wrap");
    chk("wrap_out", longint'(bus1.dsp_out[0]), -64'sd68719476736);
    chk("wrap_ovf", longint'(bus1.dsp_ovf[0]), 1);
    set_ops(0, 0);
    step(1'b1, "wrap_hold");
    chk("wrap_ovf_sticky", longint'(bus1.dsp_ovf[0]), 1);
    acc_clr = 1'b1;
    step(1'b0, "wrap_clr_noce");
    chk("wrap_clr_noce", longint'(bus1.dsp_ovf[0]), 1);
    step(1'b1, "wrap_clr");
    chk("wrap_clr_ovf", longint'(bus1.dsp_ovf[0]), 0);
    chk("wrap_clr_out", longint'(bus1.dsp_out[0]), 0);
    acc_clr = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
